// File: rtl/exc_source.sv
// Exception-source stage: IRQ synchronizer, auto-reload timer, sticky pending bits,
// fixed-priority dispatch (irq > invalid > timer) with Exc/EStatus hand-off and lost-event count.
module exc_source #(
  parameter int TIMER_W = 16,
  parameter int LOST_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ExtIRQ,
  input  logic               InvalidOp,
  input  logic               TimerLoad,
  input  logic [TIMER_W-1:0] TimerValue,
  input  logic               ExcAck,
  input  logic               ERet,
  output logic               Exc,
  output logic [3:0]         EStatus,
  output logic [2:0]         Pending,
  output logic [LOST_W-1:0]  LostCount
);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_HANDLER} state_t;

  localparam logic [3:0] CODE_IRQ = 4'b0001;
  localparam logic [3:0] CODE_INV = 4'b0010;
  localparam logic [3:0] CODE_TMR = 4'b0011;

  state_t             state_q, state_d;
  logic               sync1_q, sync2_q, sync3_q;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [TIMER_W-1:0] reload_q, reload_d;
  logic [2:0]         pend_q, pend_d;
  logic [2:0]         evt, clr;
  logic [LOST_W-1:0]  lost_q, lost_d;
  logic               exc_q, exc_d;
  logic [3:0]         estatus_q, estatus_d;
  logic               irq_evt, tmr_evt;

  assign irq_evt = sync2_q & ~sync3_q;
  // A load in the expiry cycle takes precedence and suppresses the event.
  assign tmr_evt = ~TimerLoad & (reload_q != '0) & (cnt_q == TIMER_W'(1));
  assign evt     = {tmr_evt, InvalidOp, irq_evt};

  always_comb begin
    reload_d = reload_q;
    cnt_d    = cnt_q;
    if (TimerLoad) begin
      reload_d = TimerValue;
      cnt_d    = TimerValue;
    end else if (reload_q != '0) begin
      if (cnt_q == TIMER_W'(1)) cnt_d = reload_q;
      else                      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  // A bit being cleared by dispatch this cycle still counts as set, so a
  // coincident event on it is lost rather than re-latched.
  always_comb begin
    pend_d = (pend_q & ~clr) | (evt & ~pend_q);
    lost_d = lost_q;
    if (|(evt & pend_q) && (lost_q != '1)) lost_d = lost_q + LOST_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (pend_q != 3'b000) state_d = S_PENDING;
      S_PENDING: if (ExcAck)           state_d = S_HANDLER;
      S_HANDLER: if (ERet)             state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clr       = 3'b000;
    exc_d     = exc_q;
    estatus_d = estatus_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q[0]) begin
          clr       = 3'b001;
          estatus_d = CODE_IRQ;
          exc_d     = 1'b1;
        end else if (pend_q[1]) begin
          clr       = 3'b010;
          estatus_d = CODE_INV;
          exc_d     = 1'b1;
        end else if (pend_q[2]) begin
          clr       = 3'b100;
          estatus_d = CODE_TMR;
          exc_d     = 1'b1;
        end
      end
      S_PENDING: if (ExcAck) exc_d = 1'b0;
      S_HANDLER: if (ERet)   estatus_d = 4'b0000;
      default: begin
        exc_d     = 1'b0;
        estatus_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      cnt_q     <= '0;
      reload_q  <= '0;
      pend_q    <= 3'b000;
      lost_q    <= '0;
      exc_q     <= 1'b0;
      estatus_q <= 4'b0000;
    end else begin
      state_q   <= state_d;
      sync1_q   <= ExtIRQ;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      pend_q    <= pend_d;
      lost_q    <= lost_d;
      exc_q     <= exc_d;
      estatus_q <= estatus_d;
    end
  end

  assign Exc       = exc_q;
  assign EStatus   = estatus_q;
  assign Pending   = pend_q;
  assign LostCount = lost_q;

endmodule

// File: tb/tb_exc_source.sv
// Directed bench for exc_source: dispatch codes go through a scoreboard queue checked
// by a monitor on each Exc rise; other state is checked inline against hand-computed values.
module tb_exc_source;

  logic        clk;
  logic        reset;
  logic        ExtIRQ, InvalidOp, TimerLoad, ExcAck, ERet;
  logic [15:0] TimerValue;
  logic        Exc;
  logic [3:0]  EStatus;
  logic [2:0]  Pending;
  logic [7:0]  LostCount;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];
  logic       exc_prev;

  exc_source #(.TIMER_W(16), .LOST_W(8)) dut (
    .clk(clk), .reset(reset), .ExtIRQ(ExtIRQ), .InvalidOp(InvalidOp),
    .TimerLoad(TimerLoad), .TimerValue(TimerValue), .ExcAck(ExcAck), .ERet(ERet),
    .Exc(Exc), .EStatus(EStatus), .Pending(Pending), .LostCount(LostCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic irq_events(input int n);
    repeat (n) begin
      ExtIRQ = 1'b1;
      tick(1);
      ExtIRQ = 1'b0;
      tick(1);
    end
  endtask

  task automatic ack_and_return();
    ExcAck = 1'b1;
    tick(1);
    ExcAck = 1'b0;
    ERet = 1'b1;
    tick(1);
    ERet = 1'b0;
  endtask

  // Scoreboard monitor: every new dispatch must match the next queued cause code.
  initial begin
    exc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (Exc && !exc_prev) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL dispatch_unexpected: got EStatus %0h expected no dispatch at %0t", EStatus, $time);
        end else begin
          check("dispatch_code", 32'(EStatus), 32'(exp_q.pop_front()));
        end
      end
      exc_prev = Exc;
    end
  end

  initial begin
    reset = 1'b1;
    ExtIRQ = 1'b0; InvalidOp = 1'b0; TimerLoad = 1'b0; ExcAck = 1'b0; ERet = 1'b0;
    TimerValue = 16'd0;
    tick(2);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_outputs", {17'd0, Exc, EStatus, Pending, LostCount}, 32'd0);
    end

    // Single invalid-opcode exception, full handshake
    InvalidOp = 1'b1;
    exp_q.push_back(4'b0010);
    tick(1);
    InvalidOp = 1'b0;
    check("inv_pending_set", 32'(Pending), 32'b010);
    check("inv_no_exc_yet", 32'(Exc), 32'd0);
    tick(1);
    check("inv_exc", 32'(Exc), 32'd1);
    check("inv_estatus", 32'(EStatus), 32'b0010);
    check("inv_pending_clr", 32'(Pending), 32'd0);
    tick(2);
    ExcAck = 1'b1;
    tick(1);
    ExcAck = 1'b0;
    check("inv_ack_exc", 32'(Exc), 32'd0);
    check("inv_ack_estatus", 32'(EStatus), 32'b0010);
    tick(2);
    ERet = 1'b1;
    tick(1);
    ERet = 1'b0;
    check("inv_eret_estatus", 32'(EStatus), 32'd0);
    tick(1);
    check("inv_idle_exc", 32'(Exc), 32'd0);

    // IRQ and invalid pending together: irq first, invalid one edge after ERet
    ExtIRQ = 1'b1;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    tick(2);
    InvalidOp = 1'b1;
    tick(1);
    InvalidOp = 1'b0;
    check("both_pending", 32'(Pending), 32'b011);
    tick(1);
    check("prio_exc", 32'(Exc), 32'd1);
    check("prio_estatus_irq", 32'(EStatus), 32'b0001);
    check("prio_pending_left", 32'(Pending), 32'b010);
    ERet = 1'b1;
    tick(1);
    ERet = 1'b0;
    check("eret_ignored_pending", 32'({Exc, EStatus}), 32'h11);
    ExcAck = 1'b1;
    tick(1);
    ExcAck = 1'b0;
    check("prio_ack_exc", 32'(Exc), 32'd0);
    ERet = 1'b1;
    tick(1);
    ERet = 1'b0;
    check("prio_eret_state", 32'({Exc, EStatus, Pending}), 32'b0_0000_010);
    tick(1);
    check("second_exc", 32'(Exc), 32'd1);
    check("second_estatus", 32'(EStatus), 32'b0010);
    check("second_pending", 32'(Pending), 32'd0);
    ack_and_return();
    tick(5);
    check("held_level_one_event", 32'({Exc, Pending}), 32'd0);
    ExtIRQ = 1'b0;
    tick(4);
    check("no_lost_so_far", 32'(LostCount), 32'd0);

    // Timer with reload 4, exception left unacknowledged for 20 cycles
    TimerValue = 16'd4;
    TimerLoad = 1'b1;
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0011);
    tick(1);
    TimerLoad = 1'b0;
    tick(3);
    check("tmr_not_yet", 32'(Pending), 32'd0);
    tick(1);
    check("tmr_first_evt", 32'(Pending), 32'b100);
    tick(1);
    check("tmr_dispatch", 32'({Exc, EStatus, Pending}), 32'b1_0011_000);
    tick(20);
    check("tmr_held_exc", 32'(Exc), 32'd1);
    check("tmr_repending", 32'(Pending), 32'b100);
    check("tmr_lost4", 32'(LostCount), 32'd4);
    TimerValue = 16'd0;
    TimerLoad = 1'b1;
    tick(1);
    TimerLoad = 1'b0;
    ack_and_return();
    tick(1);
    check("tmr_second_dispatch", 32'({Exc, EStatus, Pending}), 32'b1_0011_000);
    ack_and_return();
    tick(8);
    check("tmr_disabled", 32'({Exc, Pending, LostCount}), 32'd4);

    // Lost IRQ events while parked in HANDLER, up to saturation
    InvalidOp = 1'b1;
    exp_q.push_back(4'b0010);
    tick(1);
    InvalidOp = 1'b0;
    tick(1);
    ExcAck = 1'b1;
    tick(1);
    ExcAck = 1'b0;
    irq_events(10);
    tick(3);
    check("lost_pending_irq", 32'(Pending), 32'b001);
    check("lost_13", 32'(LostCount), 32'd13);
    check("handler_no_dispatch", 32'(Exc), 32'd0);
    irq_events(300);
    tick(3);
    check("lost_saturated", 32'(LostCount), 32'd255);

    // Async reset while an exception is outstanding
    ERet = 1'b1;
    exp_q.push_back(4'b0001);
    tick(1);
    ERet = 1'b0;
    tick(1);
    check("pre_reset_exc", 32'({Exc, EStatus}), 32'h11);
    TimerValue = 16'd3;
    TimerLoad = 1'b1;
    InvalidOp = 1'b1;
    tick(1);
    TimerLoad = 1'b0;
    InvalidOp = 1'b0;
    check("pre_reset_pending", 32'(Pending), 32'b010);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_clear", {17'd0, Exc, EStatus, Pending, LostCount}, 32'd0);
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("post_reset_quiet", 32'({Exc, EStatus, Pending}), 32'd0);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
